// File: rtl/led_pwm_fader_pkg.sv
// led_pwm_fader_pkg: shared widths, brightness limit, channel states and saturating step helper
package led_pwm_fader_pkg;
  localparam int PWM_BITS = 8;
  localparam logic [PWM_BITS-1:0] BRIGHT_MAX = 8'd255;
  typedef enum logic [1:0] {OFF, RISE, ON, FALL} ch_state_e;
  function automatic logic [PWM_BITS-1:0] sat_step(input logic [PWM_BITS-1:0] b, input logic [PWM_BITS-1:0] s, input logic up);
    logic [PWM_BITS:0] sum;
    sum = {1'b0, b} + {1'b0, s};
    return up ? (sum[PWM_BITS] ? BRIGHT_MAX : sum[PWM_BITS-1:0]) : (b > s ? b - s : '0);
  endfunction
endpackage

// File: rtl/led_pwm_fader_if.sv
// led_pwm_fader_if: blink-stage request in, dimmed LED drive and fade status out
interface led_pwm_fader_if;
  logic [3:0] led_in;
  logic [3:0] prled;
  logic       fading;
  modport master (output led_in, input prled, fading);
  modport slave (input led_in, output prled, fading);
endinterface

// File: rtl/led_pwm_fader_channel.sv
// led_fade_channel: one LED's brightness ramp state machine and PWM comparator
module led_fade_channel
  import led_pwm_fader_pkg::*;
#(
  parameter int STEP = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_i,
  input  logic                tick_i,
  input  logic [PWM_BITS-1:0] pwm_cnt_i,
  output logic                prled_o,
  output logic                busy_o
);
  localparam logic [PWM_BITS-1:0] STEP_V = PWM_BITS'(STEP);
  logic [PWM_BITS-1:0] b_q, b_d;
  ch_state_e state_q, state_d;
  logic prled_q;
  // direction follows req; ticks move brightness, state is derived from where it lands
  always_comb begin
    b_d = tick_i ? sat_step(b_q, STEP_V, req_i) : b_q;
    state_d = req_i ? (b_d == BRIGHT_MAX ? ON : RISE) : (b_d == '0 ? OFF : FALL);
  end
  // brightness, state and the registered active-low PWM drive
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      b_q     <= '0;
      state_q <= OFF;
      prled_q <= 1'b1;
    end else begin
      b_q     <= b_d;
      state_q <= state_d;
      prled_q <= ~((b_q == BRIGHT_MAX) | (pwm_cnt_i < b_q));
    end
  end
  assign prled_o = prled_q;
  assign busy_o  = (state_q == RISE) || (state_q == FALL);
endmodule

// File: rtl/led_pwm_fader.sv
// led_pwm_fader: 4-channel PWM fader between the blink stage and the board LEDs
module led_pwm_fader
  import led_pwm_fader_pkg::*;
#(
  parameter int FADE_DIV = 50000,
  parameter int STEP     = 1
) (
  input  logic      clk,
  input  logic      rst,
  led_pwm_fader_if.slave bus
);
  localparam int DW = $clog2(FADE_DIV);
  logic [3:0] sync_q, req_q, prled_w, busy_w;
  logic [PWM_BITS-1:0] pwm_cnt_q;
  logic [DW-1:0] pre_q;
  logic fading_q, tick;
  assign tick = pre_q == DW'(FADE_DIV - 1);
  // request synchronizer, free-running PWM counter, step prescaler and fade status
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q    <= '0;
      req_q     <= '0;
      pwm_cnt_q <= '0;
      pre_q     <= '0;
      fading_q  <= 1'b0;
    end else begin
      sync_q    <= bus.led_in;
      req_q     <= sync_q;
      pwm_cnt_q <= pwm_cnt_q + PWM_BITS'(1);
      pre_q     <= tick ? '0 : pre_q + DW'(1);
      fading_q  <= |busy_w;
    end
  end
  for (genvar i = 0; i < 4; i++) begin : g_ch
    led_fade_channel #(.STEP(STEP)) u_ch (
      .clk       (clk),
      .rst       (rst),
      .req_i     (req_q[i]),
      .tick_i    (tick),
      .pwm_cnt_i (pwm_cnt_q),
      .prled_o   (prled_w[i]),
      .busy_o    (busy_w[i])
    );
  end
  assign bus.prled  = prled_w;
  assign bus.fading = fading_q;
endmodule

// File: tb/tb_led_pwm_fader.sv
// tb_led_pwm_fader: directed vectors plus ramp, saturation and reset sequences
module tb_led_pwm_fader;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  led_pwm_fader_if if_a ();
  led_pwm_fader_if if_b ();
  led_pwm_fader_if if_c ();
  led_pwm_fader_if if_d ();

  led_pwm_fader #(.FADE_DIV(2),    .STEP(1))   u_a (.clk(clk), .rst(rst), .bus(if_a));
  led_pwm_fader #(.FADE_DIV(1024), .STEP(64))  u_b (.clk(clk), .rst(rst), .bus(if_b));
  led_pwm_fader #(.FADE_DIV(264),  .STEP(1))   u_c (.clk(clk), .rst(rst), .bus(if_c));
  led_pwm_fader #(.FADE_DIV(1024), .STEP(200)) u_d (.clk(clk), .rst(rst), .bus(if_d));

  int ecnt;
  int n_chk = 0;
  int n_fail = 0;
  int lows [4];

  // edges since reset release; matches every prescaler count modulo FADE_DIV
  always @(posedge clk or negedge rst) begin
    if (!rst) ecnt <= 0;
    else ecnt <= ecnt + 1;
  end

  typedef struct packed {
    logic [3:0]      led;
    logic [3:0][8:0] d;
    logic            f;
  } vec_t;
  vec_t vecs [7];

  function automatic logic [3:0] prled_of(input int inst);
    case (inst)
      0: return if_a.prled;
      1: return if_b.prled;
      2: return if_c.prled;
      default: return if_d.prled;
    endcase
  endfunction

  function automatic logic fading_of(input int inst);
    case (inst)
      0: return if_a.fading;
      1: return if_b.fading;
      2: return if_c.fading;
      default: return if_d.fading;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step_clk();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_phase(input int fd, input int ph);
    int k = 0;
    do begin
      step_clk();
      k++;
    end while ((ecnt % fd) != ph && k <= fd + 1);
    if ((ecnt % fd) != ph) begin
      n_chk++;
      n_fail++;
      $display("FAIL wait_phase: phase %0d never reached", ph);
    end
  endtask

  task automatic measure(input int inst);
    logic [3:0] p;
    for (int c = 0; c < 4; c++) lows[c] = 0;
    repeat (256) begin
      step_clk();
      p = prled_of(inst);
      for (int c = 0; c < 4; c++) if (p[c] == 1'b0) lows[c]++;
    end
  endtask

  task automatic ramp_seq(input string nm);
    int r = 0;
    while (if_a.fading !== 1'b1 && r < 10) begin
      step_clk();
      r++;
    end
    chk({nm, " fading rise edge"}, r, 4);
    while (if_a.fading !== 1'b0 && r < 700) begin
      step_clk();
      r++;
    end
    chk({nm, " fading fall edge"}, r, 513);
  endtask

  initial begin
    vecs[0] = '{led: 4'b0001, d: {9'd0, 9'd0,   9'd0,   9'd64},  f: 1'b1};
    vecs[1] = '{led: 4'b0011, d: {9'd0, 9'd0,   9'd64,  9'd128}, f: 1'b1};
    vecs[2] = '{led: 4'b0010, d: {9'd0, 9'd0,   9'd128, 9'd64},  f: 1'b1};
    vecs[3] = '{led: 4'b1010, d: {9'd64, 9'd0,  9'd192, 9'd0},   f: 1'b1};
    vecs[4] = '{led: 4'b1010, d: {9'd128, 9'd0, 9'd256, 9'd0},   f: 1'b1};
    vecs[5] = '{led: 4'b0000, d: {9'd64, 9'd0,  9'd191, 9'd0},   f: 1'b1};
    vecs[6] = '{led: 4'b0010, d: {9'd0, 9'd0,   9'd256, 9'd0},   f: 1'b0};

    if_a.led_in = 4'hf;
    if_b.led_in = 4'hf;
    if_c.led_in = 4'hf;
    if_d.led_in = 4'hf;
    repeat (10) begin
      step_clk();
      chk("reset prled", prled_of(0), 4'hf);
      chk("reset fading", fading_of(0), 0);
    end
    if_a.led_in = 4'h0;
    if_b.led_in = 4'h0;
    if_c.led_in = 4'h0;
    if_d.led_in = 4'h0;
    @(negedge clk);
    rst = 1'b1;

    wait_phase(2, 0);
    if_a.led_in = 4'b0001;
    ramp_seq("rise");
    measure(0);
    chk("full on lows ch0", lows[0], 256);
    chk("full on lows ch1", lows[1], 0);
    wait_phase(2, 0);
    if_a.led_in = 4'b0000;
    ramp_seq("fall");
    measure(0);
    chk("off lows ch0", lows[0], 0);

    for (int v = 0; v < 7; v++) begin
      wait_phase(1024, 300);
      if_b.led_in = vecs[v].led;
      wait_phase(1024, 1);
      measure(1);
      for (int c = 0; c < 4; c++) chk($sformatf("vec%0d ch%0d lows", v, c), lows[c], vecs[v].d[c]);
      chk($sformatf("vec%0d fading", v), fading_of(1), vecs[v].f);
    end

    wait_phase(1024, 300);
    if_d.led_in = 4'b0001;
    wait_phase(1024, 1);
    measure(3);
    chk("step200 first tick", lows[0], 200);
    chk("step200 rising fading", fading_of(3), 1);
    wait_phase(1024, 1);
    measure(3);
    chk("step200 saturate high", lows[0], 256);
    chk("step200 on fading", fading_of(3), 0);
    wait_phase(1024, 300);
    if_d.led_in = 4'b0000;
    wait_phase(1024, 1);
    measure(3);
    chk("step200 fall to 55", lows[0], 55);
    chk("step200 falling fading", fading_of(3), 1);
    wait_phase(1024, 1);
    measure(3);
    chk("step200 saturate low", lows[0], 0);
    chk("step200 off fading", fading_of(3), 0);

    wait_phase(264, 100);
    if_c.led_in = 4'b0001;
    repeat (100) wait_phase(264, 1);
    measure(2);
    chk("b100 lows", lows[0], 100);
    wait_phase(264, 260);
    if_c.led_in = 4'b0000;
    wait_phase(264, 1);
    measure(2);
    chk("reverse no jump lows", lows[0], 99);
    chk("reverse fading", fading_of(2), 1);

    if_a.led_in = 4'hf;
    repeat (20) step_clk();
    chk("midfade fading before reset", fading_of(0), 1);
    #2 rst = 1'b0;
    #1;
    chk("async reset prled", prled_of(0), 4'hf);
    chk("async reset fading", fading_of(0), 0);
    repeat (3) begin
      step_clk();
      chk("held reset prled", prled_of(0), 4'hf);
    end
    @(negedge clk);
    rst = 1'b1;
    begin
      int r = 0;
      while (if_a.fading !== 1'b1 && r < 10) begin
        step_clk();
        r++;
      end
      chk("restart from OFF latency", r, 4);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/led_pwm_fader.md
LED_PWM_FADER -- requirements
Module: led_pwm_fader

Interface
REQ-001 The block SHALL have one clock and one reset; reset is asynchronous and active-low.
REQ-002 Parameter FADE_DIV, default 50000, SHALL set the clock cycles per brightness step (legal range >= 2).
REQ-003 Parameter STEP, default 1, SHALL set the brightness increment/decrement per step (1..255).
REQ-004 clk  input  1  system clock.
REQ-005 rst  input  1  asynchronous active-low reset.
REQ-006 led_in  input  4  on/off pattern from the blink stage (1 = LED requested on), asynchronous to clk.
REQ-007 prled  output  4  PWM-dimmed board LED drive, active-low (0 = lit).
REQ-008 fading  output  1  high while any channel is in RISE or FALL.

Function
REQ-009 led_in SHALL pass through a 2-flop synchronizer per bit; req[i] denotes the synchronized value.
REQ-010 A free-running 8-bit pwm_cnt SHALL increment every clock and wrap 255->0.
REQ-011 A prescaler SHALL count 0..FADE_DIV-1; tick SHALL pulse for one cycle when the count equals FADE_DIV-1, and the count then SHALL return to 0.
REQ-012 Each channel SHALL hold an 8-bit brightness b[i] and a state from {OFF, RISE, ON, FALL}.
REQ-013 OFF: b=0; req=1 -> RISE (same cycle req is seen, no tick needed).
REQ-014 RISE: on tick, b <= min(b+STEP, 255); b reaching 255 -> ON; req=0 -> FALL without changing b.
REQ-015 ON: b=255; req=0 -> FALL.
REQ-016 FALL: on tick, b <= max(b-STEP, 0); b reaching 0 -> OFF; req=1 -> RISE without changing b.
REQ-017 Addition and subtraction SHALL saturate; b SHALL never wrap.
REQ-018 A req change and a tick in the same cycle SHALL apply the step in the new direction.
REQ-019 req pulses shorter than one tick period SHALL still change state; b moves only on ticks.
REQ-020 prled[i] SHALL be registered: prled[i] <= ~((b[i]==255) | (pwm_cnt < b[i])); b=0 gives constant off, b=255 gives constant on.
REQ-021 fading SHALL be registered and equal the OR of (state==RISE or FALL) over all channels, one cycle behind state.
REQ-022 Latency from a led_in edge to the state change SHALL be 2 clocks (synchronizer); state to prled update 1 clock.

Reset
REQ-023 While rst=0: prled=4'b1111, fading=0, all b=0, all states OFF, pwm_cnt=0, prescaler=0, synchronizer flops=0.
REQ-024 Reset asserted mid-fade SHALL abort immediately to REQ-023 values; after release channels start from OFF.
REQ-025 The first pwm_cnt increment and prescaler count SHALL occur on the first clock edge after rst deasserts.

Structure
REQ-026 A shared package SHALL hold PWM_BITS=8, BRIGHT_MAX=255 and the channel state enum {OFF, RISE, ON, FALL}.
REQ-027 A sub-module led_fade_channel (req, tick, pwm_cnt in; prled bit, busy out) SHALL be instantiated 4 times; the top holds the synchronizer, pwm_cnt, prescaler and the fading OR.
REQ-028 The block SHALL sit between the blink stage output and the board LED pins.

Verification
REQ-029 Reset held 10 clocks with led_in=4'b1111 -> prled=4'b1111, fading=0 throughout.
REQ-030 FADE_DIV=2, STEP=1, led_in 0->4'b0001 -> state RISE after 2 clocks, fading=1, b[0]=255 after 255 ticks (510 clocks), state ON, prled[0]=0 constantly, fading=0.
REQ-031 From ON, led_in[0]=0 with FADE_DIV=2, STEP=1 -> b[0] reaches 0 after 510 clocks, prled[0]=1 constantly, state OFF.
REQ-032 b[0]=64 held (STEP=64, one tick) -> prled[0] low for exactly 64 of every 256 clocks.
REQ-033 RISE at b=100, led_in drops 1 cycle before tick -> next tick gives b=99 (STEP=1), state FALL, no jump.
REQ-034 STEP=200 from b=100 rising -> b saturates at 255, state ON; falling from 100 -> b=0, state OFF.
